uart_rx_frame_ctrl: RTL and testbench

//  Frame controller behind the RS-232 byte receiver. Parses bytes into frames:

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_frame_buf.sv | 36 +++
 rtl/uart_rx_frame_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the RS-232 frame controller: state and error encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  // Frame parser states; CHK is only reachable when the checksum build option is on.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CHK     = 3'd3,
    DRAIN   = 3'd4,
    ABORT   = 3'd5
  } frm_state_t;

  // Error codes reported on frm_err_code alongside the frm_error strobe.
  typedef enum logic [1:0] {
    ERR_OVR = 2'b00,  // byte arrived while the payload was still draining
    ERR_LEN = 2'b01,  // LEN byte zero or larger than the buffer
    ERR_CHK = 2'b10,  // payload plus checksum byte did not wrap to zero
    ERR_TMO = 2'b11   // inter-byte timeout or line idle inside a frame
  } frm_err_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // A LEN byte is usable only if it names 1..max_len payload bytes.
  function automatic logic len_is_bad(input logic [7:0] len_byte, input logic [7:0] max_len);
    return (len_byte == 8'd0) || (len_byte > max_len);
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store: DEPTH x 8 register array, synchronous write, combinational read.
// Latency: written byte readable the cycle after wr_en; read path has no register.
// Backpressure: none; the controller never writes and drains the same frame at once.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 5
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0] mem [DEPTH];

  logic wr_in_range;
  logic rd_in_range;

  assign wr_in_range = (wr_addr < AW'(DEPTH));
  assign rd_in_range = (rd_addr < AW'(DEPTH));

  // Storage is deliberately not reset: contents are only read after being written.
  always_ff @(posedge clock) begin
    if (wr_en && wr_in_range) begin
      mem[wr_addr[IW-1:0]] <= wr_data;
    end
  end

  // The controller may present one-past-the-end while retiring the final byte.
  assign rd_data = rd_in_range ? mem[rd_addr[IW-1:0]] : 8'h00;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frames receiver bytes (SYNC, LEN, payload[, CHK]) and streams the payload out; build option RX_FRAME_CHECKSUM_EN adds the CHK byte.
// Latency: all outputs registered, one clock after the cause; frm_valid rises the cycle after the closing byte.
// Backpressure: frm_ready low holds frm_data/frm_last; bytes arriving while draining are dropped with an overrun error.
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         MAX_LEN        = 16,
  parameter int         LEN_W          = 5,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset_neg,
  input  logic       rx_dataout_ready,
  input  logic [7:0] rx_dataout,
  input  logic       rx_endofpacket,
  output logic       rx_abort,
  output logic       frm_valid,
  input  logic       frm_ready,
  output logic [7:0] frm_data,
  output logic       frm_last,
  output logic       frm_error,
  output logic [1:0] frm_err_code
);

  localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       MAX_LEN8 = 8'(MAX_LEN);

  frm_state_t       state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] wr_ptr;
  logic [LEN_W-1:0] rd_ptr;
  logic [TMR_W-1:0] timer;
`ifdef RX_FRAME_CHECKSUM_EN
  logic [7:0]       sum_q;
  logic [7:0]       chk_sum;
`endif

  logic             rx_byte;
  logic             tmo_hit;
  logic             pay_last;
  logic             len_one;
  logic             xfer;
  logic             next_is_last;
  logic             abort_req;
  frm_err_t         abort_code;
  logic             buf_wr_en;
  logic [LEN_W-1:0] buf_rd_addr;
  logic [7:0]       buf_rd;

  assign rx_byte      = rx_dataout_ready;
  assign tmo_hit      = rx_endofpacket || (timer == TMR_LAST);
  assign pay_last     = (wr_ptr == (len_q - LEN_W'(1)));
  assign len_one      = (len_q == LEN_W'(1));
  assign xfer         = frm_valid && frm_ready;
  // In DRAIN the buffer is addressed one ahead so the next byte is ready on transfer.
  assign buf_rd_addr  = (state == DRAIN) ? (rd_ptr + LEN_W'(1)) : '0;
  assign next_is_last = (buf_rd_addr == (len_q - LEN_W'(1)));
  assign buf_wr_en    = (state == PAYLOAD) && rx_byte;
`ifdef RX_FRAME_CHECKSUM_EN
  assign chk_sum      = sum_q + rx_dataout;
`endif

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (LEN_W)
  ) u_frame_buf (
    .clock   (clock),
    .wr_en   (buf_wr_en),
    .wr_addr (wr_ptr),
    .wr_data (rx_dataout),
    .rd_addr (buf_rd_addr),
    .rd_data (buf_rd)
  );

  // Abort decision; a byte always beats a timeout or line-idle in the same clock.
  always_comb begin
    abort_req  = 1'b0;
    abort_code = ERR_TMO;
    case (state)
      LEN: begin
        if (rx_byte && len_is_bad(rx_dataout, MAX_LEN8)) begin
          abort_req  = 1'b1;
          abort_code = ERR_LEN;
        end else if (!rx_byte && tmo_hit) begin
          abort_req  = 1'b1;
          abort_code = ERR_TMO;
        end
      end
      PAYLOAD: begin
        if (!rx_byte && tmo_hit) begin
          abort_req  = 1'b1;
          abort_code = ERR_TMO;
        end
      end
`ifdef RX_FRAME_CHECKSUM_EN
      CHK: begin
        if (rx_byte && (chk_sum != 8'h00)) begin
          abort_req  = 1'b1;
          abort_code = ERR_CHK;
        end else if (!rx_byte && tmo_hit) begin
          abort_req  = 1'b1;
          abort_code = ERR_TMO;
        end
      end
`endif
      default: begin
        abort_req  = 1'b0;
        abort_code = ERR_TMO;
      end
    endcase
  end

  // Frame sequencer: state, pointers, timer and every registered output.
  always_ff @(posedge clock or negedge reset_neg) begin
    if (!reset_neg) begin
      state        <= IDLE;
      len_q        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      timer        <= '0;
`ifdef RX_FRAME_CHECKSUM_EN
      sum_q        <= '0;
`endif
      rx_abort     <= 1'b0;
      frm_valid    <= 1'b0;
      frm_data     <= '0;
      frm_last     <= 1'b0;
      frm_error    <= 1'b0;
      frm_err_code <= '0;
    end else begin
      rx_abort  <= 1'b0;
      frm_error <= 1'b0;
      if (abort_req) begin
        state        <= ABORT;
        rx_abort     <= 1'b1;
        frm_error    <= 1'b1;
        frm_err_code <= abort_code;
        len_q        <= '0;
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        timer        <= '0;
`ifdef RX_FRAME_CHECKSUM_EN
        sum_q        <= '0;
`endif
      end else begin
        case (state)
          IDLE: begin
            timer <= '0;
            if (rx_byte && (rx_dataout == SYNC_BYTE)) begin
              state <= LEN;
            end
          end
          LEN: begin
            if (rx_byte) begin
              timer  <= '0;
              len_q  <= LEN_W'(rx_dataout);
              wr_ptr <= '0;
`ifdef RX_FRAME_CHECKSUM_EN
              sum_q  <= '0;
`endif
              state  <= PAYLOAD;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end
          PAYLOAD: begin
            if (rx_byte) begin
              timer  <= '0;
              wr_ptr <= wr_ptr + LEN_W'(1);
`ifdef RX_FRAME_CHECKSUM_EN
              sum_q  <= sum_q + rx_dataout;
              if (pay_last) begin
                state <= CHK;
              end
`else
              if (pay_last) begin
                state     <= DRAIN;
                rd_ptr    <= '0;
                frm_valid <= 1'b1;
                // A one-byte frame is written this very edge, so bypass the array.
                frm_data  <= len_one ? rx_dataout : buf_rd;
                frm_last  <= len_one;
              end
`endif
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end
`ifdef RX_FRAME_CHECKSUM_EN
          CHK: begin
            if (rx_byte) begin
              timer     <= '0;
              state     <= DRAIN;
              rd_ptr    <= '0;
              frm_valid <= 1'b1;
              frm_data  <= buf_rd;
              frm_last  <= len_one;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end
`endif
          DRAIN: begin
            if (rx_byte) begin
              frm_error    <= 1'b1;
              frm_err_code <= ERR_OVR;
            end
            if (xfer) begin
              if (frm_last) begin
                state     <= IDLE;
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                frm_valid <= 1'b0;
                frm_data  <= '0;
                frm_last  <= 1'b0;
              end else begin
                rd_ptr   <= buf_rd_addr;
                frm_data <= buf_rd;
                frm_last <= next_is_last;
              end
            end
          end
          ABORT: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: vector table plus corner-case sequences.
// Works with and without RX_FRAME_CHECKSUM_EN; checksum bytes are appended when enabled.
// A negedge monitor counts error/abort strobes and captures every accepted payload byte.
module tb_uart_rx_frame_ctrl;

  localparam int TMO = 40;

`ifdef RX_FRAME_CHECKSUM_EN
  localparam logic CHK_ON = 1'b1;
`else
  localparam logic CHK_ON = 1'b0;
`endif

  logic       clock;
  logic       reset_neg;
  logic       rx_dataout_ready;
  logic [7:0] rx_dataout;
  logic       rx_endofpacket;
  logic       rx_abort;
  logic       frm_valid;
  logic       frm_ready;
  logic [7:0] frm_data;
  logic       frm_last;
  logic       frm_error;
  logic [1:0] frm_err_code;

  uart_rx_frame_ctrl #(
    .SYNC_BYTE      (8'hA5),
    .MAX_LEN        (16),
    .LEN_W          (5),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock            (clock),
    .reset_neg        (reset_neg),
    .rx_dataout_ready (rx_dataout_ready),
    .rx_dataout       (rx_dataout),
    .rx_endofpacket   (rx_endofpacket),
    .rx_abort         (rx_abort),
    .frm_valid        (frm_valid),
    .frm_ready        (frm_ready),
    .frm_data         (frm_data),
    .frm_last         (frm_last),
    .frm_error        (frm_error),
    .frm_err_code     (frm_err_code)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  int         err_cnt   = 0;
  int         abort_cnt = 0;
  logic [1:0] last_code = 2'b00;
  int         out_n     = 0;
  logic [7:0] out_d [256];
  logic       out_l [256];
  logic       stall_q = 1'b0;
  logic [7:0] hold_d  = 8'h00;
  logic       hold_l  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: strobe counting, payload capture and hold-under-backpressure checks.
  always @(negedge clock) begin
    if (!reset_neg) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_valid", {31'd0, frm_valid}, 32'd1);
        check("hold_data", {24'd0, frm_data}, {24'd0, hold_d});
        check("hold_last", {31'd0, frm_last}, {31'd0, hold_l});
      end
      if (frm_error) begin
        err_cnt++;
        last_code = frm_err_code;
      end
      if (rx_abort) abort_cnt++;
      if (frm_valid && frm_ready && out_n < 256) begin
        out_d[out_n] = frm_data;
        out_l[out_n] = frm_last;
        out_n++;
      end
      stall_q = frm_valid && !frm_ready;
      hold_d  = frm_data;
      hold_l  = frm_last;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // One-clock byte strobe; consecutive calls leave one idle clock between bytes.
  task automatic send_byte(input logic [7:0] b);
    @(posedge clock);
    #1;
    rx_dataout_ready = 1'b1;
    rx_dataout       = b;
    @(posedge clock);
    #1;
    rx_dataout_ready = 1'b0;
  endtask

  typedef struct packed {
    logic [4:0]  n;          // stimulus byte count
    logic [63:0] b;          // stimulus bytes, first byte in [63:56]
    logic        has_chk;    // append chk byte after the stimulus
    logic [7:0]  chk;
    logic [3:0]  exp_err;
    logic [1:0]  exp_code;
    logic [3:0]  exp_abort;
    logic [3:0]  exp_out;
    logic [31:0] exp_d;      // expected payload, first byte in [31:24]
  } vec_t;

  vec_t vecs [8];
  int   nvec;

  task automatic run_vec(input int k, input vec_t v);
    int e0, a0, o0;
    e0 = err_cnt;
    a0 = abort_cnt;
    o0 = out_n;
    frm_ready = 1'b1;
    for (int i = 0; i < int'(v.n); i++) send_byte(v.b[63-8*i -: 8]);
    if (v.has_chk) send_byte(v.chk);
    idle(int'(v.exp_out) + 6);
    check($sformatf("v%0d_errs", k), err_cnt - e0, {28'd0, v.exp_err});
    if (v.exp_err != 4'd0) check($sformatf("v%0d_code", k), {30'd0, last_code}, {30'd0, v.exp_code});
    check($sformatf("v%0d_aborts", k), abort_cnt - a0, {28'd0, v.exp_abort});
    check($sformatf("v%0d_count", k), out_n - o0, {28'd0, v.exp_out});
    for (int j = 0; j < int'(v.exp_out); j++) begin
      check($sformatf("v%0d_data%0d", k, j), {24'd0, out_d[o0+j]}, {24'd0, v.exp_d[31-8*j -: 8]});
      check($sformatf("v%0d_last%0d", k, j), {31'd0, out_l[o0+j]}, {31'd0, (j == int'(v.exp_out) - 1)});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int e0, a0, o0, n;
    logic [7:0] s;
    logic [7:0] pay [16];

    // Checksum bytes make the 8-bit sum of payload plus CHK wrap to zero.
    vecs[0] = '{n:5'd5, b:64'hA5_03_11_22_33_00_00_00, has_chk:CHK_ON, chk:8'h9A,
                exp_err:4'd0, exp_code:2'd0, exp_abort:4'd0, exp_out:4'd3, exp_d:32'h11_22_33_00};
    vecs[1] = '{n:5'd6, b:64'h00_5A_A5_02_DE_AD_00_00, has_chk:CHK_ON, chk:8'h75,
                exp_err:4'd0, exp_code:2'd0, exp_abort:4'd0, exp_out:4'd2, exp_d:32'hDE_AD_00_00};
    vecs[2] = '{n:5'd2, b:64'hA5_00_00_00_00_00_00_00, has_chk:1'b0, chk:8'h00,
                exp_err:4'd1, exp_code:2'b01, exp_abort:4'd1, exp_out:4'd0, exp_d:32'h0};
    vecs[3] = '{n:5'd2, b:64'hA5_11_00_00_00_00_00_00, has_chk:1'b0, chk:8'h00,
                exp_err:4'd1, exp_code:2'b01, exp_abort:4'd1, exp_out:4'd0, exp_d:32'h0};
    vecs[4] = '{n:5'd3, b:64'hA5_01_7E_00_00_00_00_00, has_chk:CHK_ON, chk:8'h82,
                exp_err:4'd0, exp_code:2'd0, exp_abort:4'd0, exp_out:4'd1, exp_d:32'h7E_00_00_00};
    vecs[5] = '{n:5'd4, b:64'hA5_02_A5_5A_00_00_00_00, has_chk:CHK_ON, chk:8'h01,
                exp_err:4'd0, exp_code:2'd0, exp_abort:4'd0, exp_out:4'd2, exp_d:32'hA5_5A_00_00};
    nvec = 6;
`ifdef RX_FRAME_CHECKSUM_EN
    vecs[6] = '{n:5'd5, b:64'hA5_03_11_22_33_00_00_00, has_chk:1'b1, chk:8'h00,
                exp_err:4'd1, exp_code:2'b10, exp_abort:4'd1, exp_out:4'd0, exp_d:32'h0};
    nvec = 7;
`endif

    reset_neg        = 1'b0;
    rx_dataout_ready = 1'b0;
    rx_dataout       = 8'h00;
    rx_endofpacket   = 1'b0;
    frm_ready        = 1'b1;
    idle(3);
    check("rst_valid", {31'd0, frm_valid}, 32'd0);
    check("rst_data", {24'd0, frm_data}, 32'd0);
    check("rst_last", {31'd0, frm_last}, 32'd0);
    check("rst_error", {31'd0, frm_error}, 32'd0);
    check("rst_code", {30'd0, frm_err_code}, 32'd0);
    check("rst_abort", {31'd0, rx_abort}, 32'd0);
    reset_neg = 1'b1;
    idle(3);
    check("rst_no_abort_pulse", abort_cnt, 32'd0);
    check("rst_no_error_pulse", err_cnt, 32'd0);

    for (int k = 0; k < nvec; k++) run_vec(k, vecs[k]);

    // Inter-byte timeout: error exactly TMO clocks after the last byte.
    e0 = err_cnt; a0 = abort_cnt; o0 = out_n;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h44);
    n = 0;
    while (!frm_error && n < TMO + 10) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("tmo_latency", n, TMO);
    check("tmo_code", {30'd0, frm_err_code}, 32'd3);
    idle(3);
    check("tmo_aborts", abort_cnt - a0, 32'd1);
    check("tmo_errs", err_cnt - e0, 32'd1);
    check("tmo_no_out", out_n - o0, 32'd0);

    // Line idle inside a frame aborts on the next clock.
    e0 = err_cnt; a0 = abort_cnt;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h44);
    idle(2);
    rx_endofpacket = 1'b1;
    idle(1);
    rx_endofpacket = 1'b0;
    check("eop_error", {31'd0, frm_error}, 32'd1);
    check("eop_code", {30'd0, frm_err_code}, 32'd3);
    idle(3);
    check("eop_aborts", abort_cnt - a0, 32'd1);
    check("eop_errs", err_cnt - e0, 32'd1);

    // Byte and line-idle together: the byte wins and the frame completes.
    e0 = err_cnt; o0 = out_n;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h44);
    @(posedge clock);
    #1;
    rx_dataout_ready = 1'b1;
    rx_dataout       = 8'h55;
    rx_endofpacket   = 1'b1;
    idle(1);
    rx_dataout_ready = 1'b0;
    rx_endofpacket   = 1'b0;
    if (CHK_ON) send_byte(8'h67);
    idle(6);
    check("sim_errs", err_cnt - e0, 32'd0);
    check("sim_count", out_n - o0, 32'd2);
    check("sim_d0", {24'd0, out_d[o0]}, 32'h44);
    check("sim_d1", {24'd0, out_d[o0+1]}, 32'h55);

    // Overrun under backpressure: two dropped bytes, payload intact afterwards.
    e0 = err_cnt; a0 = abort_cnt; o0 = out_n;
    frm_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    if (CHK_ON) send_byte(8'h9A);
    check("ovr_valid_latency", {31'd0, frm_valid}, 32'd1);
    check("ovr_first_data", {24'd0, frm_data}, 32'h11);
    check("ovr_first_last", {31'd0, frm_last}, 32'd0);
    idle(3);
    send_byte(8'h77);
    idle(2);
    send_byte(8'hA5);
    idle(8);
    check("ovr_errs", err_cnt - e0, 32'd2);
    check("ovr_code", {30'd0, last_code}, 32'd0);
    check("ovr_aborts", abort_cnt - a0, 32'd0);
    check("ovr_held", out_n - o0, 32'd0);
    check("ovr_still_valid", {31'd0, frm_valid}, 32'd1);
    frm_ready = 1'b1;
    idle(6);
    check("ovr_count", out_n - o0, 32'd3);
    check("ovr_d0", {24'd0, out_d[o0]}, 32'h11);
    check("ovr_d1", {24'd0, out_d[o0+1]}, 32'h22);
    check("ovr_d2", {24'd0, out_d[o0+2]}, 32'h33);
    check("ovr_last", {31'd0, out_l[o0+2]}, 32'd1);

    // Largest legal frame fills the whole buffer.
    e0 = err_cnt; o0 = out_n;
    s = 8'h00;
    for (int i = 0; i < 16; i++) begin
      pay[i] = 8'(i * 7 + 3);
      s = s + pay[i];
    end
    send_byte(8'hA5); send_byte(8'h10);
    for (int i = 0; i < 16; i++) send_byte(pay[i]);
    if (CHK_ON) send_byte(8'(8'h00 - s));
    idle(24);
    check("max_errs", err_cnt - e0, 32'd0);
    check("max_count", out_n - o0, 32'd16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("max_d%0d", i), {24'd0, out_d[o0+i]}, {24'd0, pay[i]});
      check($sformatf("max_last%0d", i), {31'd0, out_l[o0+i]}, {31'd0, (i == 15)});
    end

    // Reset mid-PAYLOAD, then a clean frame.
    send_byte(8'hA5); send_byte(8'h05); send_byte(8'h01); send_byte(8'h02);
    @(posedge clock);
    #2;
    reset_neg = 1'b0;
    #1;
    check("rstp_valid", {31'd0, frm_valid}, 32'd0);
    check("rstp_error", {31'd0, frm_error}, 32'd0);
    check("rstp_abort", {31'd0, rx_abort}, 32'd0);
    idle(2);
    reset_neg = 1'b1;
    e0 = err_cnt; a0 = abort_cnt; o0 = out_n;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hC3); send_byte(8'h3C);
    if (CHK_ON) send_byte(8'h01);
    idle(6);
    check("rstp_errs", err_cnt - e0, 32'd0);
    check("rstp_aborts", abort_cnt - a0, 32'd0);
    check("rstp_count", out_n - o0, 32'd2);
    check("rstp_d0", {24'd0, out_d[o0]}, 32'hC3);
    check("rstp_d1", {24'd0, out_d[o0+1]}, 32'h3C);

    // Reset while a byte is held for the consumer: outputs drop immediately.
    frm_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h99);
    if (CHK_ON) send_byte(8'h67);
    idle(2);
    check("rstd_pre_valid", {31'd0, frm_valid}, 32'd1);
    check("rstd_pre_data", {24'd0, frm_data}, 32'h99);
    @(posedge clock);
    #2;
    reset_neg = 1'b0;
    #1;
    check("rstd_valid", {31'd0, frm_valid}, 32'd0);
    check("rstd_data", {24'd0, frm_data}, 32'd0);
    check("rstd_last", {31'd0, frm_last}, 32'd0);
    idle(2);
    reset_neg = 1'b1;
    o0 = out_n;
    frm_ready = 1'b1;
    idle(5);
    check("rstd_no_out", out_n - o0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
